// File: rtl/uart_rx_framed.sv
// UART receiver: rx synchroniser, free-running oversample tick, start/data/parity/stop
// deframer and a single-entry valid/ready holding register. Optional: UART_RX_MAJORITY_EN.
module uart_rx_framed #(
  parameter int CLK_FREQ   = 30000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx_framed: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_rx_framed: OVERSAMPLE must be even and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_rx_framed: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_rx_framed: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
    $error("uart_rx_framed: STOP_BITS must be 1 or 2");
  end

  // With majority voting every decision moves one tick past the nominal point,
  // so the post-start realignment starts the sub-counter at 1 instead of 0.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] START_DEC  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_DEC    = '0;
  localparam logic [SW-1:0] SC_REALIGN = SW'(1);
`else
  localparam logic [SW-1:0] START_DEC  = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] BIT_DEC    = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SC_REALIGN = '0;
`endif
  localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [SW-1:0]        sc;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_val;
  logic                 start_dec, bit_dec, done;
  logic                 perr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt <= '0;
    else if (div_cnt == DW'(DIV - 1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DW'(DIV - 1));

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hist <= '1;
    else if (tick)
      hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (tick && !rx_s) state_n = S_START;
      S_START:  if (start_dec) state_n = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (bit_dec && bcnt == BCNT_LAST) state_n = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_dec) state_n = S_STOP;
      S_STOP:   if (bit_dec) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    start_dec = tick && (state == S_START) && (sc == START_DEC);
    bit_dec   = tick && (state == S_DATA || state == S_PARITY || state == S_STOP)
                && (sc == BIT_DEC);
    done      = bit_dec && (state == S_STOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc      <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (tick) begin
      unique case (state)
        S_IDLE: begin
          sc   <= '0;
          bcnt <= '0;
        end
        S_START: sc <= (sc == START_DEC) ? SC_REALIGN : sc + 1'b1;
        default: begin
          sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
          if (bit_dec && state == S_DATA) begin
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            bcnt  <= bcnt + 1'b1;
          end
          if (bit_dec && state == S_PARITY)
            par_bit <= bit_val;
        end
      endcase
    end
  end

  always_comb begin
    if (PARITY == 1)
      perr_n = ~^{shreg, par_bit};
    else if (PARITY == 2)
      perr_n = ^{shreg, par_bit};
    else
      perr_n = 1'b0;
  end

  // A word arriving while the previous one is still unaccepted is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      if (!m_valid || m_ready) begin
        m_data     <= shreg;
        parity_err <= perr_n;
        frame_err  <= ~bit_val;
        m_valid    <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
